// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types, default widths and branch-target table
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam int FETCH_PW = 10;
    localparam int FETCH_LW = 3;

    // Absolute branch targets; the assembler emits LutIdx values against this table.
    localparam int LUT_POP = 6;
    localparam logic [15:0] BRANCH_LUT [0:LUT_POP-1] = '{
        16'd12, 16'd50, 16'd200, 16'd100, 16'd511, 16'd1000
    };

endpackage

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - combinational branch-target lookup; unpopulated indices return 0
module branch_lut
    import fetch_pkg::*;
#(
    parameter int PW = FETCH_PW,
    parameter int LW = FETCH_LW
) (
    input  logic [LW-1:0] idx,
    output logic [PW-1:0] target
);

    always_comb begin
        target = '0;
        for (int i = 0; i < LUT_POP; i++) begin
            if (idx == LW'(i)) begin
                target = PW'(BRANCH_LUT[i]);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register and IDLE/RUN/HALT fetch sequencer
// Optional run-cycle counter on CycleCnt is built when FETCH_CYCLE_CNT_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PW = FETCH_PW,
    parameter int LW = FETCH_LW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [PW-1:0] StartAddr,
    input  logic          Branch,
    input  logic          BranchTaken,
    input  logic [LW-1:0] LutIdx,
    input  logic          DoneIn,
    output logic [PW-1:0] ProgCtr,
    output logic          Running,
    output logic          Done
`ifdef FETCH_CYCLE_CNT_EN
    ,
    output logic [15:0]   CycleCnt
`endif
);

    fetch_state_e  state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [PW-1:0] lut_target;

    branch_lut #(.PW(PW), .LW(LW)) u_branch_lut (
        .idx    (LutIdx),
        .target (lut_target)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = StartAddr;
                end
            end
            ST_RUN: begin
                // DONE outranks a branch issued by the same instruction.
                if (DoneIn) begin
                    state_d = ST_HALT;
                end else if (Branch && BranchTaken) begin
                    pc_d = lut_target;
                end else begin
                    pc_d = pc_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    assign ProgCtr = pc_q;
    assign Running = (state_q == ST_RUN);
    assign Done    = (state_q == ST_HALT);

`ifdef FETCH_CYCLE_CNT_EN
    logic        start_accept;
    logic [15:0] cnt_q;

    assign start_accept = Start && ((state_q == ST_IDLE) || (state_q == ST_HALT));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else if (start_accept) begin
            cnt_q <= '0;
        end else if ((state_q == ST_RUN) && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign CycleCnt = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [9:0] StartAddr;
    logic       Branch;
    logic       BranchTaken;
    logic [2:0] LutIdx;
    logic       DoneIn;
    logic [9:0] ProgCtr;
    logic       Running;
    logic       Done;
`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] CycleCnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(.PW(10), .LW(3)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .StartAddr   (StartAddr),
        .Branch      (Branch),
        .BranchTaken (BranchTaken),
        .LutIdx      (LutIdx),
        .DoneIn      (DoneIn),
        .ProgCtr     (ProgCtr),
        .Running     (Running),
        .Done        (Done)
`ifdef FETCH_CYCLE_CNT_EN
        ,
        .CycleCnt    (CycleCnt)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic [9:0] addr;
        logic       br;
        logic       tk;
        logic [2:0] idx;
        logic       dn;
        logic [9:0] exp_pc;
        logic       exp_run;
        logic       exp_done;
    } vec_t;

    function automatic vec_t mk(logic rst, logic start, logic [9:0] addr, logic br, logic tk,
                                logic [2:0] idx, logic dn, logic [9:0] pc, logic run, logic done);
        vec_t v;
        v.rst = rst; v.start = start; v.addr = addr; v.br = br; v.tk = tk; v.idx = idx;
        v.dn = dn; v.exp_pc = pc; v.exp_run = run; v.exp_done = done;
        return v;
    endfunction

    task automatic step(input logic rst, input logic start, input logic [9:0] addr,
                        input logic br, input logic tk, input logic [2:0] idx, input logic dn);
        @(negedge Clk);
        Reset = rst; Start = start; StartAddr = addr;
        Branch = br; BranchTaken = tk; LutIdx = idx; DoneIn = dn;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_state(input string name, input logic [9:0] pc, input logic run,
                               input logic done);
        check({name, " ProgCtr"}, int'(ProgCtr), int'(pc));
        check({name, " Running"}, int'(Running), int'(run));
        check({name, " Done"}, int'(Done), int'(done));
    endtask

    vec_t vecs[19];

    initial begin
        Reset = 1'b0; Start = 1'b0; StartAddr = '0;
        Branch = 1'b0; BranchTaken = 1'b0; LutIdx = '0; DoneIn = 1'b0;

        //            rst   st    addr    br    tk    idx   dn    pc       run   done
        vecs[0]  = mk(1'b0, 1'b1, 10'd5,  1'b0, 1'b0, 3'd0, 1'b0, 10'd0,   1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 10'd5,  1'b1, 1'b1, 3'd3, 1'b0, 10'd0,   1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b1, 10'd5,  1'b0, 1'b0, 3'd0, 1'b0, 10'd5,   1'b1, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 10'd0,  1'b0, 1'b0, 3'd0, 1'b0, 10'd6,   1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 10'd0,  1'b0, 1'b0, 3'd0, 1'b0, 10'd7,   1'b1, 1'b0);
        vecs[5]  = mk(1'b1, 1'b1, 10'd9,  1'b0, 1'b0, 3'd0, 1'b0, 10'd8,   1'b1, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 10'd0,  1'b1, 1'b0, 3'd3, 1'b0, 10'd9,   1'b1, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 10'd0,  1'b1, 1'b1, 3'd3, 1'b0, 10'd100, 1'b1, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 10'd0,  1'b1, 1'b1, 3'd6, 1'b0, 10'd0,   1'b1, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 10'd0,  1'b1, 1'b1, 3'd4, 1'b0, 10'd511, 1'b1, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 10'd0,  1'b0, 1'b1, 3'd3, 1'b0, 10'd512, 1'b1, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 10'd0,  1'b1, 1'b1, 3'd3, 1'b1, 10'd512, 1'b0, 1'b1);
        vecs[12] = mk(1'b1, 1'b0, 10'd0,  1'b0, 1'b0, 3'd0, 1'b0, 10'd512, 1'b0, 1'b1);
        vecs[13] = mk(1'b1, 1'b0, 10'd0,  1'b1, 1'b1, 3'd3, 1'b1, 10'd512, 1'b0, 1'b1);
        vecs[14] = mk(1'b1, 1'b1, 10'd20, 1'b0, 1'b0, 3'd0, 1'b0, 10'd20,  1'b1, 1'b0);
        vecs[15] = mk(1'b1, 1'b0, 10'd0,  1'b1, 1'b1, 3'd7, 1'b0, 10'd0,   1'b1, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 10'd33, 1'b1, 1'b1, 3'd3, 1'b1, 10'd0,   1'b0, 1'b0);
        vecs[17] = mk(1'b1, 1'b0, 10'd0,  1'b1, 1'b1, 3'd3, 1'b0, 10'd0,   1'b0, 1'b0);
        vecs[18] = mk(1'b1, 1'b0, 10'd0,  1'b0, 1'b0, 3'd0, 1'b1, 10'd0,   1'b0, 1'b0);

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].addr, vecs[i].br, vecs[i].tk,
                 vecs[i].idx, vecs[i].dn);
            check_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_run,
                        vecs[i].exp_done);
        end

        // Taken vs not-taken branch from PC 20.
        step(1'b1, 1'b1, 10'd20, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 10'd0,  1'b1, 1'b1, 3'd3, 1'b0);
        check_state("br_taken", 10'd100, 1'b1, 1'b0);
        step(1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b1, 10'd20, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 10'd0,  1'b1, 1'b0, 3'd3, 1'b0);
        check_state("br_not_taken", 10'd21, 1'b1, 1'b0);

        // PC wrap at 2^PW-1.
        step(1'b0, 1'b0, 10'd0,    1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b1, 10'd1022, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 10'd0,    1'b0, 1'b0, 3'd0, 1'b0);
        check_state("pre_wrap", 10'd1023, 1'b1, 1'b0);
        step(1'b1, 1'b0, 10'd0,    1'b0, 1'b0, 3'd0, 1'b0);
        check_state("wrap", 10'd0, 1'b1, 1'b0);

        // DONE beats a taken branch at PC 40, then re-run from 0 without reset.
        step(1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b1, 10'd40, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 10'd0,  1'b1, 1'b1, 3'd3, 1'b1);
        check_state("done_wins", 10'd40, 1'b0, 1'b1);
        step(1'b1, 1'b1, 10'd0,  1'b0, 1'b0, 3'd0, 1'b0);
        check_state("rerun", 10'd0, 1'b1, 1'b0);

        // Reset mid-run at PC 77, then a branch in IDLE.
        step(1'b1, 1'b1, 10'd76, 1'b0, 1'b0, 3'd0, 1'b1);
        check_state("halt_before_77", 10'd0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 10'd76, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 10'd0,  1'b0, 1'b0, 3'd0, 1'b0);
        check_state("at_77", 10'd77, 1'b1, 1'b0);
        step(1'b0, 1'b0, 10'd0,  1'b1, 1'b1, 3'd3, 1'b0);
        check_state("mid_reset", 10'd0, 1'b0, 1'b0);
`ifdef FETCH_CYCLE_CNT_EN
        check("cnt_reset", int'(CycleCnt), 0);
`endif
        step(1'b1, 1'b0, 10'd0,  1'b1, 1'b1, 3'd3, 1'b0);
        check_state("idle_branch", 10'd0, 1'b0, 1'b0);

`ifdef FETCH_CYCLE_CNT_EN
        // 12 RUN cycles ending with DONE, hold through HALT, clear on new Start.
        step(1'b1, 1'b1, 10'd300, 1'b0, 1'b0, 3'd0, 1'b0);
        check("cnt_start", int'(CycleCnt), 0);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 3'd0, 1'b1);
        check("cnt_done", int'(CycleCnt), 12);
        check_state("cnt_halt", 10'd311, 1'b0, 1'b1);
        step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("cnt_hold", int'(CycleCnt), 12);
        step(1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("cnt_clear", int'(CycleCnt), 0);
        step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("cnt_one", int'(CycleCnt), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch-sequencing stage sitting directly upstream of the control decoder. Holds the PC that addresses the instruction ROM and advances it each cycle. Consumes the decoder's `Branch` and `Done` outputs, plus the ALU branch condition, to select the next PC. Provides the Start/Done handshake with the testbench/top level.

## Interface
Parameters:
- `PW`, 10: program-counter width (instruction ROM depth 2^PW).
- `LW`, 3: branch-LUT index width (2^LW absolute targets).

Ports:
- `Clk`, input, 1: single clock. All state updates on its rising edge.
- `Reset`, input, 1: reset, synchronous, active-low (low at a rising `Clk` edge resets the block).
- `Start`, input, 1: level/pulse request to begin execution.
- `StartAddr`, input, PW: PC loaded when a run begins.
- `Branch`, input, 1: from the control decoder; current instruction is a branch.
- `BranchTaken`, input, 1: condition result from the ALU for the current instruction.
- `LutIdx`, input, LW: branch-target LUT index (instruction bits [2:0]).
- `DoneIn`, input, 1: from the control decoder; current instruction is DONE.
- `ProgCtr`, output, PW: current PC; drives instruction-ROM address.
- `Running`, output, 1: high in state RUN.
- `Done`, output, 1: high in state HALT (program finished).
- `CycleCnt`, output, 16: only present with `FETCH_CYCLE_CNT_EN`; see Configuration.

## Operation
- FSM states: IDLE, RUN, HALT.
- IDLE:
  - `Start`=1 → RUN, `ProgCtr` ← `StartAddr`.
  - `Branch`, `DoneIn` and `BranchTaken` are ignored; PC holds.
- RUN, evaluated in priority order each cycle:
  - `DoneIn`=1 → HALT, PC holds. DONE wins over a simultaneous `Branch`.
  - else `Branch`=1 and `BranchTaken`=1 → PC ← LUT[`LutIdx`] (absolute target).
  - else (including `Branch`=1, `BranchTaken`=0) → PC ← PC+1, modulo 2^PW. 2^PW−1 wraps to 0 silently.
  - `Start` is ignored while in RUN.
- HALT:
  - PC frozen, `Done`=1.
  - `Start`=1 → RUN with PC ← `StartAddr` (re-run without reset).
- Branch LUT: 2^LW entries of PW bits, constant contents. An index outside the populated entries returns 0.
- Reset (mid-run included): state ← IDLE, PC ← 0, all in-flight branch/done requests discarded.

## Timing
- Reset values: `ProgCtr`=0, `Running`=0, `Done`=0, `CycleCnt`=0.
- ROM read is combinational on `ProgCtr`. Decoder outputs and `BranchTaken` are valid in the same cycle and sampled at the next edge. PC update latency is 1 cycle; there are no stalls and no bubbles.
- `Start` sampled at edge N in IDLE/HALT: `Running`=1 and `ProgCtr`=`StartAddr` from edge N. The first instruction executes in cycle N.
- `DoneIn` sampled at edge M: `Done`=1 and `Running`=0 from edge M. `Done` stays high until the next accepted `Start` or reset.
- `Start` and `Reset` low in the same cycle: reset wins.

## Configuration
- `FETCH_CYCLE_CNT_EN` defined:
  - 16-bit `CycleCnt` clears on an accepted `Start`.
  - Increments once per RUN cycle and saturates at 16'hFFFF.
  - Holds in HALT and IDLE.
- Not defined: no counter logic and no `CycleCnt` port. All other behaviour is identical.

## Structure
- Shared package `fetch_pkg`:
  - FSM state enum (IDLE/RUN/HALT).
  - `PW`/`LW` default constants.
  - Branch-target constant array `BRANCH_LUT`, which the assembler must keep in sync.
- Sub-module `branch_lut`: combinational index → target lookup over `BRANCH_LUT`. Everything else lives in `fetch_unit`.

## Test plan
- Reset=0 for 2 cycles with `Start`=1 → `ProgCtr`=0, `Running`=0, `Done`=0. Release reset, `Start`=1, `StartAddr`=5 → PC=5, then 6, 7 on the following cycles.
- RUN at PC=20, `Branch`=1, `BranchTaken`=1, `LutIdx`=3, `BRANCH_LUT[3]`=100 → PC=100 next cycle. Same with `BranchTaken`=0 → PC=21.
- PC=1023 (PW=10) with no branch → PC=0 next cycle, `Running` still 1.
- `DoneIn`=1 and taken `Branch` in the same cycle at PC=40 → `Done`=1, PC stays 40. `Start`=1 with `StartAddr`=0 → PC=0, `Done`=0.
- Reset=0 mid-run at PC=77 → next cycle PC=0, IDLE, `Running`=0. A subsequent `Branch`=1 in IDLE leaves PC=0.
- With `FETCH_CYCLE_CNT_EN`: Start, then 12 RUN cycles, then DONE → `CycleCnt`=12, held through HALT. A new Start clears it to 0.
